// File: rtl/smooth_pkg.sv
// ============================================================================
// Module  : smooth_pkg
// Purpose : Shared types for the 3x3 smoothening window sequencer: default
//           pixel width, pixel/window types and the sequencer state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package smooth_pkg;

  // Pixel width expected by the smoothening kernel input.
  localparam int DATA_W_DEFAULT = 12;

  typedef logic [DATA_W_DEFAULT-1:0] pixel_t;

  // Row-major 3x3 window: [0] = top-left, [8] = bottom-right.
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/smooth_window_seq_if.sv
// ============================================================================
// Module  : smooth_window_seq_if
// Purpose : Pixel-in / window-out stream bundle of the window sequencer.
// Ports   : pix_in, pix_valid, pix_ready   raster pixel stream
//           win, win_valid, win_ready      3x3 window stream toward kernel
//           modport master = stream source/sink (environment side)
//           modport slave  = sequencer side
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface smooth_window_seq_if #(
  parameter int DATA_W = smooth_pkg::DATA_W_DEFAULT
);

  logic [DATA_W-1:0]      pix_in;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [8:0][DATA_W-1:0] win;
  logic                   win_valid;
  logic                   win_ready;

  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win, win_valid
  );

  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win, win_valid
  );

endinterface

`default_nettype wire

// File: rtl/smooth_line_buf.sv
// ============================================================================
// Module  : smooth_line_buf
// Purpose : Two-row line buffer, IMG_W deep. Row lb0 holds the previous row,
//           lb1 the row before that. Reading and writing the same column in
//           one cycle returns the old contents (read-before-write).
// Ports   : clk           clock
//           i_we          write enable (pixel accepted)
//           i_col         column address
//           i_din         incoming pixel
//           o_lb0, o_lb1  stored pixels at i_col (one and two rows up)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smooth_line_buf #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(IMG_W)-1:0] i_col,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_lb0,
  output logic [DATA_W-1:0]        o_lb1
);

  // Storage only; contents are not reset.
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];

  assign o_lb0 = r_lb0[i_col];
  assign o_lb1 = r_lb1[i_col];

  // Column c ages by one row: lb0 moves up into lb1, new pixel lands in lb0.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_lb1[i_col] <= r_lb0[i_col];
      r_lb0[i_col] <= i_din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/smooth_window_seq.sv
// ============================================================================
// Module  : smooth_window_seq
// Purpose : Frame sequencer for the 3x3 smoothening kernel. Consumes one
//           raster-order frame per start pulse, assembles 3x3 windows from
//           two line buffers and hands each interior window to the kernel
//           over valid/ready. Border pixels produce no window.
// Ports   : clk        clock, rising edge
//           reset      asynchronous, active-high
//           start      1-cycle pulse, starts a frame when idle
//           bus        smooth_window_seq_if.slave (pixel in / window out)
//           busy       frame in progress
//           done       1-cycle pulse after the last window is accepted
//           win_count  windows accepted this frame (SMOOTH_STATUS_EN only)
// Config  : `define SMOOTH_STATUS_EN adds the saturating win_count output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smooth_window_seq
  import smooth_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  smooth_window_seq_if.slave  bus,
  output logic                busy,
  output logic                done
`ifdef SMOOTH_STATUS_EN
  ,
  output logic [15:0]         win_count
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);

  seq_state_t             r_state;
  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  // Two most recent columns, index 0 is the older one (window column 0).
  logic [1:0][DATA_W-1:0] r_top;
  logic [1:0][DATA_W-1:0] r_mid;
  logic [1:0][DATA_W-1:0] r_bot;
  logic [8:0][DATA_W-1:0] r_win;
  logic                   r_win_valid;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_pix_ready;
  logic                   w_pix_take;
  logic                   w_win_take;
  logic                   w_last_pix;
  logic                   w_emit;
  logic [DATA_W-1:0]      w_lb0;
  logic [DATA_W-1:0]      w_lb1;

  // A held window blocks new pixels unless it is being taken this cycle,
  // which lets a new window replace it back-to-back at one pixel per clock.
  assign w_pix_ready = (r_state == RUN) && (!r_win_valid || bus.win_ready);
  assign w_pix_take  = bus.pix_valid && w_pix_ready;
  assign w_win_take  = r_win_valid && bus.win_ready;
  assign w_last_pix  = (r_row == c_row_last) && (r_col == c_col_last);
  // The first window of each row appears at column 2, once all three
  // columns come from the current row set.
  assign w_emit      = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  smooth_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_line_buf (
    .clk    (clk),
    .i_we   (w_pix_take),
    .i_col  (r_col),
    .i_din  (bus.pix_in),
    .o_lb0  (w_lb0),
    .o_lb1  (w_lb1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_top       <= '0;
      r_mid       <= '0;
      r_bot       <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_win_take) begin
        r_win_valid <= 1'b0;
      end

      if (w_pix_take) begin
        r_top <= {w_lb1, r_top[1]};
        r_mid <= {w_lb0, r_mid[1]};
        r_bot <= {bus.pix_in, r_bot[1]};

        if (w_emit) begin
          r_win_valid <= 1'b1;
          r_win[0]    <= r_top[0];
          r_win[1]    <= r_top[1];
          r_win[2]    <= w_lb1;
          r_win[3]    <= r_mid[0];
          r_win[4]    <= r_mid[1];
          r_win[5]    <= w_lb0;
          r_win[6]    <= r_bot[0];
          r_win[7]    <= r_bot[1];
          r_win[8]    <= bus.pix_in;
        end

        // Counters never run past the frame: the last pixel returns both
        // to zero instead of bumping the row.
        if (r_col == c_col_last) begin
          r_col <= '0;
          r_row <= w_last_pix ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        RUN: begin
          if (w_pix_take && w_last_pix) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!r_win_valid) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SMOOTH_STATUS_EN
  logic [15:0] r_win_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_win_count <= '0;
    end else if (w_win_take && (r_win_count != 16'hFFFF)) begin
      r_win_count <= r_win_count + 16'd1;
    end
  end

  assign win_count = r_win_count;
`endif

  assign bus.pix_ready = w_pix_ready;
  assign bus.win       = r_win;
  assign bus.win_valid = r_win_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

`default_nettype wire
